// File: rtl/pkg_ecualizador.sv
// Shared definitions for the equalizer channel sequencers: FSM state encoding
// and the default number of MAC taps per sample.
package pkg_ecualizador;

    localparam int unsigned TAPS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CARGA  = 3'd1,
        MAC    = 3'd2,
        SALIDA = 3'd3,
        FIN    = 3'd4
    } estado_t;

endpackage

// File: rtl/secuenciador_pipeline_filtro.sv
// Sequencer for one equalizer filter channel: drives the active-low load
// enables of the input/accumulator/output pipeline registers and steps the
// coefficient address through one MAC pass per audio sample.
// Optional macro SECUENCIADOR_CNT_OVERRUN_EN adds a saturating dropped-tick
// counter on output cnt_overrun.
module secuenciador_pipeline_filtro
    import pkg_ecualizador::*;
#(
    parameter  int unsigned TAPS = TAPS_DEF,
    localparam int unsigned CW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_muestra,
    input  logic          pausa,
    input  logic          clr_overrun,
    output logic          en_entrada_n,
    output logic          en_acum_n,
    output logic          en_salida_n,
    output logic          clr_acum,
    output logic [CW-1:0] dir_coef,
    output logic          listo,
    output logic          ocupado,
    output logic          overrun
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
    ,
    output logic [7:0]    cnt_overrun
`endif
);

    localparam logic [CW-1:0] ULTIMO = CW'(TAPS - 1);

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic          en_entrada_q;
    logic          en_acum_q;
    logic          en_salida_q;
    logic          clr_acum_q;
    logic          listo_q;
    logic          caida;

    // A tick is dropped when it lands in a state that cannot accept a new pass
    assign caida = tick_muestra && (estado == CARGA || estado == MAC || estado == SALIDA);

    // Output flops hold the Moore decode of the occupied state; pausa only
    // masks the strobes so the held values reappear unchanged on release.
    assign en_entrada_n = en_entrada_q | pausa;
    assign en_acum_n    = en_acum_q    | pausa;
    assign en_salida_n  = en_salida_q  | pausa;
    assign clr_acum     = clr_acum_q   & ~pausa;
    assign listo        = listo_q      & ~pausa;

    // FSM, tap counter, overrun flag and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= IDLE;
            cnt          <= '0;
            overrun      <= 1'b0;
            en_entrada_q <= 1'b1;
            en_acum_q    <= 1'b1;
            en_salida_q  <= 1'b1;
            clr_acum_q   <= 1'b0;
            listo_q      <= 1'b0;
            dir_coef     <= '0;
            ocupado      <= 1'b0;
        end else if (!pausa) begin
            en_entrada_q <= 1'b1;
            en_acum_q    <= 1'b1;
            en_salida_q  <= 1'b1;
            clr_acum_q   <= 1'b0;
            listo_q      <= 1'b0;
            dir_coef     <= '0;
            ocupado      <= 1'b1;

            if (caida) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (estado)
                IDLE, FIN: begin
                    if (tick_muestra) begin
                        estado       <= CARGA;
                        cnt          <= '0;
                        en_entrada_q <= 1'b0;
                        clr_acum_q   <= 1'b1;
                    end else begin
                        estado  <= IDLE;
                        ocupado <= 1'b0;
                    end
                end
                CARGA: begin
                    estado    <= MAC;
                    cnt       <= '0;
                    en_acum_q <= 1'b0;
                end
                MAC: begin
                    if (cnt == ULTIMO) begin
                        estado      <= SALIDA;
                        cnt         <= '0;
                        en_salida_q <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        en_acum_q <= 1'b0;
                        dir_coef  <= cnt + 1'b1;
                    end
                end
                SALIDA: begin
                    estado  <= FIN;
                    listo_q <= 1'b1;
                end
                default: begin
                    estado  <= IDLE;
                    cnt     <= '0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

`ifdef SECUENCIADOR_CNT_OVERRUN_EN
    // Saturating count of dropped ticks; a drop coinciding with a clear counts as one
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_overrun <= '0;
        end else if (!pausa) begin
            if (caida && clr_overrun) begin
                cnt_overrun <= 8'd1;
            end else if (clr_overrun) begin
                cnt_overrun <= '0;
            end else if (caida && cnt_overrun != 8'hFF) begin
                cnt_overrun <= cnt_overrun + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_secuenciador_pipeline_filtro.sv
// Scoreboard bench for secuenciador_pipeline_filtro. Expected outputs come from
// a pass-position model: each pass is TAPS+3 numbered cycles after a tick.
module tb_secuenciador_pipeline_filtro;

    localparam int unsigned T  = 8;
    localparam int unsigned CW = $clog2(T);

    typedef struct packed {
        logic       en_e;
        logic       en_a;
        logic       en_s;
        logic       clr;
        logic       lst;
        logic       ocu;
        logic       ovr;
        logic [7:0] dir;
        logic [7:0] cov;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset, tick_muestra, pausa, clr_overrun;
    logic          en_entrada_n, en_acum_n, en_salida_n, clr_acum, listo, ocupado, overrun;
    logic [CW-1:0] dir_coef;
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
    logic [7:0]    cnt_overrun;
`endif

    secuenciador_pipeline_filtro #(.TAPS(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_muestra (tick_muestra),
        .pausa        (pausa),
        .clr_overrun  (clr_overrun),
        .en_entrada_n (en_entrada_n),
        .en_acum_n    (en_acum_n),
        .en_salida_n  (en_salida_n),
        .clr_acum     (clr_acum),
        .dir_coef     (dir_coef),
        .listo        (listo),
        .ocupado      (ocupado),
        .overrun      (overrun)
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
        ,
        .cnt_overrun  (cnt_overrun)
`endif
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   listo_cyc = -1;
    obs_t exp_q[$];

    // Model: pos 0 = idle, pos k (1..T+3) = k-th cycle of a pass
    int   m_pos = 0;
    bit   m_ovr = 0;
    int   m_cov = 0;

    task automatic check(input string nombre, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", nombre, cyc, act, req);
    endtask

    function automatic obs_t modelo_salidas(input bit pz);
        obs_t o;
        bit en_mac;
        en_mac  = (m_pos >= 2) && (m_pos <= int'(T) + 1);
        o.en_e  = !(m_pos == 1 && !pz);
        o.en_a  = !(en_mac && !pz);
        o.en_s  = !(m_pos == int'(T) + 2 && !pz);
        o.clr   = (m_pos == 1) && !pz;
        o.lst   = (m_pos == int'(T) + 3) && !pz;
        o.ocu   = (m_pos != 0);
        o.ovr   = m_ovr;
        o.dir   = en_mac ? 8'(m_pos - 2) : 8'd0;
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
        o.cov   = 8'(m_cov);
`else
        o.cov   = 8'd0;
`endif
        return o;
    endfunction

    task automatic modelo_avanza(input bit tk, input bit pz, input bit cl, input bit rs);
        bit ocupado_m, drop;
        if (rs) begin
            m_pos = 0; m_ovr = 0; m_cov = 0;
        end else if (!pz) begin
            ocupado_m = (m_pos >= 1) && (m_pos <= int'(T) + 2);
            drop = tk && ocupado_m;
            if (drop) m_ovr = 1;
            else if (cl) m_ovr = 0;
            if (drop && cl) m_cov = 1;
            else if (cl) m_cov = 0;
            else if (drop && m_cov < 255) m_cov++;
            if (m_pos == 0 || m_pos == int'(T) + 3) m_pos = tk ? 1 : 0;
            else m_pos++;
        end
    endtask

    // One clock of stimulus: expectation for this cycle is queued before the edge
    task automatic step(input bit tk, input bit pz, input bit cl, input bit rs);
        tick_muestra = tk; pausa = pz; clr_overrun = cl; reset = rs;
        exp_q.push_back(modelo_salidas(pz));
        @(posedge clk);
        #1;
        modelo_avanza(tk, pz, cl, rs);
        cyc++;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle
    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.en_e = en_entrada_n; a.en_a = en_acum_n; a.en_s = en_salida_n;
            a.clr = clr_acum; a.lst = listo; a.ocu = ocupado; a.ovr = overrun;
            a.dir = 8'(dir_coef);
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
            a.cov = cnt_overrun;
`else
            a.cov = 8'd0;
`endif
            if (listo === 1'b1) listo_cyc = cyc;
            check("salidas", 64'(a), 64'(e));
        end
    end

    initial begin
        int base;
        reset = 1'b1; tick_muestra = 1'b0; pausa = 1'b0; clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single pass
        base = cyc; listo_cyc = -1;
        for (int i = 0; i < 15; i++) step(i == 0, 0, 0, 0);
        check("listo_pasada_simple", 64'(listo_cyc - base), 64'd11);

        // Back-to-back passes
        base = cyc; listo_cyc = -1;
        for (int i = 0; i < 26; i++) step(i == 0 || i == 11, 0, 0, 0);
        check("listo_consecutivo", 64'(listo_cyc - base), 64'd22);

        // Early tick, then clear
        base = cyc; listo_cyc = -1;
        for (int i = 0; i < 24; i++) step(i == 0 || i == 5, 0, i == 20, 0);
        check("listo_tick_temprano", 64'(listo_cyc - base), 64'd11);

        // Pause mid-MAC with an ignored tick
        base = cyc; listo_cyc = -1;
        for (int i = 0; i < 18; i++) step(i == 0 || i == 5, i >= 4 && i <= 6, 0, 0);
        check("listo_pausa", 64'(listo_cyc - base), 64'd14);

        // Reset mid-pass abandons it
        listo_cyc = -1;
        for (int i = 0; i < 16; i++) step(i == 0, 0, 0, i == 6);
        check("sin_listo_tras_reset", 64'(listo_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

`ifdef SECUENCIADOR_CNT_OVERRUN_EN
        // Saturation, then drop coinciding with clear
        for (int i = 0; i < 340; i++) step(1, 0, 0, 0);
        check("cnt_saturado", 64'(cnt_overrun), 64'd255);
        while (m_pos < 1 || m_pos > int'(T) + 2) step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        check("cnt_caida_y_clr", 64'(cnt_overrun), 64'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        step(0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("cola_vacia", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
